// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle control unit for a simple register-file processor.
// Fetches a 9-bit instruction into IR and sequences bus/ALU enables over T0..T3.
module proc_ctrl #(
    parameter int IW = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] din,
    output logic [7:0]  rin,
    output logic [7:0]  rout,
    output logic        ain,
    output logic        gin,
    output logic        gout,
    output logic        dinout,
    output logic        addsub,
    output logic        done
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          irin;

    logic [2:0] op, x, y;
    logic [7:0] x_oh, y_oh;
    logic       is_arith;

    // Upper din bits only carry data onto the datapath bus, never into IR.
    logic unused_din;
    assign unused_din = ^din[15:IW];

    assign op       = ir_q[8:6];
    assign x        = ir_q[5:3];
    assign y        = ir_q[2:0];
    assign x_oh     = 8'd1 << x;
    assign y_oh     = 8'd1 << y;
    assign is_arith = (op[2:1] == 2'b01);

    // Decode control outputs and next state from state, IR and run.
    always_comb begin
        state_d = T0;
        irin    = 1'b0;
        rin     = 8'h00;
        rout    = 8'h00;
        ain     = 1'b0;
        gin     = 1'b0;
        gout    = 1'b0;
        dinout  = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        case (state_q)
            T0: begin
                irin    = run;
                state_d = run ? T1 : T0;
            end
            T1: begin
                if (op == OP_MV) begin
                    rout = y_oh;
                    rin  = x_oh;
                    done = 1'b1;
                end else if (op == OP_MVI) begin
                    dinout = 1'b1;
                    rin    = x_oh;
                    done   = 1'b1;
                end else if (is_arith) begin
                    rout    = x_oh;
                    ain     = 1'b1;
                    state_d = T2;
                end else begin
                    done = 1'b1;
                end
            end
            T2: begin
                if (is_arith) begin
                    rout    = y_oh;
                    gin     = 1'b1;
                    addsub  = (op == OP_SUB);
                    state_d = T3;
                end
            end
            T3: begin
                if (is_arith) begin
                    gout = 1'b1;
                    rin  = x_oh;
                    done = 1'b1;
                end
            end
            default: state_d = T0;
        endcase
    end

    // IR captures the instruction only on the fetch cycle.
    always_comb begin
        ir_d = ir_q;
        if (irin) begin
            ir_d = din[IW-1:0];
        end
    end

    // State and IR registers; reset wins over any pending fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 The module SHALL have one parameter, IW, default 9, giving the instruction width taken from din[IW-1:0].
REQ-002 Port clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 Port run  input  1  start request; sampled only in state T0.
REQ-005 Port din  input  16  instruction/immediate input; din[8:0] is the instruction when latched.
REQ-006 Port rin  output  8  per-register load enable; bit k drives the en of register Rk.
REQ-007 Port rout  output  8  one-hot bus select, register Rk onto the bus.
REQ-008 Port ain  output  1  load enable of the ALU A-operand register.
REQ-009 Port gin  output  1  load enable of the ALU result register G.
REQ-010 Port gout  output  1  bus select, G onto the bus.
REQ-011 Port dinout  output  1  bus select, din onto the bus.
REQ-012 Port addsub  output  1  ALU op: 0 = add, 1 = subtract.
REQ-013 Port done  output  1  one-cycle pulse marking the final cycle of an instruction.

Function
REQ-014 Internal 9-bit IR SHALL load din[8:0] on posedge clk when irin (internal) = 1; irin = run in T0, else 0.
REQ-015 Fields: I = IR[8:6] opcode, X = IR[5:3] destination, Y = IR[2:0] source.
REQ-016 Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#din; 010 add Rx,Ry; 011 sub Rx,Ry; 1xx nop.
REQ-017 FSM states T0, T1, T2, T3. All outputs SHALL decode combinationally from state, IR and run.
REQ-018 T0: T0->T1 if run = 1, else stay T0. No output asserted except irin.
REQ-019 T1 mv: rout[Y]=1, rin[X]=1, done=1; next T0.
REQ-020 T1 mvi: dinout=1, rin[X]=1, done=1; next T0. Immediate is din during T1.
REQ-021 T1 add/sub: rout[X]=1, ain=1; next T2.
REQ-022 T1 nop: done=1 only; next T0.
REQ-023 T2 add/sub: rout[Y]=1, gin=1, addsub=(I==011); next T3.
REQ-024 T3 add/sub: gout=1, rin[X]=1, done=1; next T0.
REQ-025 Latency: mv/mvi/nop 2 cycles, add/sub 4 cycles, both counting the T0 fetch cycle.
REQ-026 At most one of rout bits, gout, dinout SHALL be 1 in any cycle.
REQ-027 At most one rin bit SHALL be 1 in any cycle.
REQ-028 X == Y is legal. mv R3,R3 asserts rout[3] and rin[3] in the same cycle.
REQ-029 run is ignored outside T0. run held high SHALL start a new fetch in the T0 immediately after done.
REQ-030 An undefined state encoding SHALL go to T0 on the next clock.

Reset
REQ-031 rst = 1 at posedge clk SHALL force state T0 and IR = 0 in any state, mid-instruction included; rst has priority over run.
REQ-032 While in T0 after reset with run = 0: rin = 0, rout = 0, ain = gin = gout = dinout = addsub = done = 0.
REQ-033 An instruction aborted by rst SHALL produce no further rin or gin pulses.

Verification
REQ-034 Reset, then mvi R2 (din=9'b001_010_000), run=1 one cycle, din=16'h00A5 in T1 -> T1: dinout=1, rin=8'h04, done=1; next cycle all outputs 0.
REQ-035 mv R5,R2 (9'b000_101_010) -> T1: rout=8'h04, rin=8'h20, done=1; total 2 cycles.
REQ-036 sub R1,R6 (9'b011_001_110):
- T1: rout=8'h02, ain=1.
- T2: rout=8'h40, gin=1, addsub=1.
- T3: gout=1, rin=8'h02, done=1.
REQ-037 add R0,R0 with run held high -> second fetch in the cycle after T3, no idle cycle; nop (9'b100_000_000) -> done in T1, rin=0.
REQ-038 rst=1 in T2 of an add -> next cycle T0, all outputs 0, IR=0, no rin pulse; a fresh instruction after reset completes correctly.
REQ-039 Every cycle of every test -> checker confirms REQ-026 and REQ-027.
